// File: rtl/jtag_tap_multichan.sv
// IEEE 1149.1 TAP model with NUM_CHAN user data-register channels, IDCODE and BYPASS.
// Scan data is sampled on posedge tck; tdo, tdo_oe and jrstn are launched on negedge tck.
//
// state  | meaning
// TLR    | Test-Logic-Reset, ir forced to IDCODE_OPCODE
// RTI    | Run-Test/Idle
// SEL_DR | Select-DR-Scan
// CAP_DR | Capture-DR
// SH_DR  | Shift-DR
// EX1_DR | Exit1-DR
// PAU_DR | Pause-DR
// EX2_DR | Exit2-DR
// UPD_DR | Update-DR
// SEL_IR | Select-IR-Scan
// CAP_IR | Capture-IR
// SH_IR  | Shift-IR
// EX1_IR | Exit1-IR
// PAU_IR | Pause-IR
// EX2_IR | Exit2-IR
// UPD_IR | Update-IR
module jtag_tap_multichan #(
  parameter int                            IR_WIDTH      = 8,
  parameter int                            NUM_CHAN      = 2,
  parameter logic [NUM_CHAN*IR_WIDTH-1:0]  CHAN_OPCODES  = {8'h38, 8'h32},
  parameter logic [IR_WIDTH-1:0]           IDCODE_OPCODE = 8'hE0,
  parameter logic [31:0]                   IDCODE_VALUE  = 32'h41111043
) (
  input  logic                tck,
  input  logic                reset,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_oe,
  output logic                jtck,
  output logic                jtdi,
  output logic                jrstn,
  output logic [NUM_CHAN-1:0] jshift,
  output logic [NUM_CHAN-1:0] jupdate,
  output logic [NUM_CHAN-1:0] jce,
  output logic [NUM_CHAN-1:0] jrti,
  input  logic [NUM_CHAN-1:0] jtdo
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } state_e;

  state_e                state_q, state_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_shift_q, ir_cap;
  logic [31:0]           idcode_sr_q;
  logic                  bypass_q;
  logic                  jtdi_q;
  logic                  tdo_q, tdo_oe_q, jrstn_q;
  logic [NUM_CHAN-1:0]   chan_sel;
  logic                  chan_hit, sel_idcode, sel_bypass, dr_tdo;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:    state_d = tms ? TLR    : RTI;
      RTI:    state_d = tms ? SEL_DR : RTI;
      SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms ? UPD_DR : PAU_DR;
      PAU_DR: state_d = tms ? EX2_DR : PAU_DR;
      EX2_DR: state_d = tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms ? SEL_DR : RTI;
      SEL_IR: state_d = tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms ? UPD_IR : PAU_IR;
      PAU_IR: state_d = tms ? EX2_IR : PAU_IR;
      EX2_IR: state_d = tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Lowest-indexed matching slice wins so at most one channel is ever selected.
  always_comb begin
    chan_sel = '0;
    chan_hit = 1'b0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (!chan_hit && ir_q == CHAN_OPCODES[i*IR_WIDTH +: IR_WIDTH]) begin
        chan_sel[i] = 1'b1;
        chan_hit    = 1'b1;
      end
    end
  end

  assign sel_idcode = !chan_hit && (ir_q == IDCODE_OPCODE);
  assign sel_bypass = !chan_hit && !sel_idcode;
  assign dr_tdo     = chan_hit ? |(jtdo & chan_sel) : (sel_idcode ? idcode_sr_q[0] : bypass_q);

  always_comb begin
    ir_cap      = ir_q;
    ir_cap[1:0] = 2'b01;
  end

  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      state_q     <= TLR;
      ir_q        <= IDCODE_OPCODE;
      ir_shift_q  <= '0;
      idcode_sr_q <= IDCODE_VALUE;
      bypass_q    <= 1'b0;
      jtdi_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      jtdi_q  <= tdi;
      case (state_q)
        TLR:    ir_q       <= IDCODE_OPCODE;
        CAP_IR: ir_shift_q <= ir_cap;
        SH_IR:  ir_shift_q <= {tdi, ir_shift_q[IR_WIDTH-1:1]};
        UPD_IR: ir_q       <= ir_shift_q;
        CAP_DR: begin
          if (sel_idcode) idcode_sr_q <= IDCODE_VALUE;
          if (sel_bypass) bypass_q    <= 1'b0;
        end
        SH_DR: begin
          if (sel_idcode) idcode_sr_q <= {tdi, idcode_sr_q[31:1]};
          if (sel_bypass) bypass_q    <= tdi;
        end
        default: ;
      endcase
    end
  end

  // Negedge launch keeps the last shifted bit on tdo through Exit1.
  always_ff @(negedge tck or posedge reset) begin
    if (reset) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
      jrstn_q  <= 1'b0;
    end else begin
      jrstn_q  <= (state_q != TLR);
      tdo_oe_q <= (state_q == SH_IR) || (state_q == SH_DR);
      if (state_q == SH_IR)      tdo_q <= ir_shift_q[0];
      else if (state_q == SH_DR) tdo_q <= dr_tdo;
    end
  end

  assign tdo     = tdo_q;
  assign tdo_oe  = tdo_oe_q;
  assign jrstn   = jrstn_q;
  assign jtck    = tck;
  assign jtdi    = jtdi_q;
  assign jshift  = (state_q == SH_DR) ? chan_sel : '0;
  assign jupdate = (state_q == UPD_DR) ? chan_sel : '0;
  assign jce     = ((state_q == CAP_DR) || (state_q == SH_DR)) ? chan_sel : '0;
  assign jrti    = (state_q == RTI) ? chan_sel : '0;

endmodule

// File: tb/tb_jtag_tap_multichan.sv
// Bench for jtag_tap_multichan: scan tasks drive TMS/TDI, expected TDO bits go into a
// scoreboard queue and are compared against the bits collected from the DUT.
module tb_jtag_tap_multichan;
  localparam int NC = 2;
  localparam logic [31:0] IDC = 32'h41111043;

  logic tck = 1'b0;
  logic reset, tms, tdi;
  logic tdo, tdo_oe, jtck, jtdi, jrstn;
  logic [NC-1:0] jshift, jupdate, jce, jrti, jtdo;

  int checks = 0;
  int failures = 0;
  logic exp_q[$];
  logic obs_q[$];

  logic s_tdo, s_oe, s_jrstn, s_jtdi;
  logic [NC-1:0] s_jshift, s_jce, s_jupdate, s_jrti;

  jtag_tap_multichan dut (
    .tck(tck), .reset(reset), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_oe(tdo_oe),
    .jtck(jtck), .jtdi(jtdi), .jrstn(jrstn), .jshift(jshift), .jupdate(jupdate),
    .jce(jce), .jrti(jrti), .jtdo(jtdo)
  );

  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One TCK cycle: strobes sampled after posedge, negedge outputs after negedge.
  task automatic tick(input logic m, input logic d);
    tms = m;
    tdi = d;
    @(posedge tck); #1;
    s_jshift = jshift; s_jce = jce; s_jupdate = jupdate; s_jrti = jrti; s_jtdi = jtdi;
    @(negedge tck); #1;
    s_tdo = tdo; s_oe = tdo_oe; s_jrstn = jrstn;
  endtask

  // Full scan from RTI back to RTI; collects one tdo bit per shifted bit into obs_q.
  task automatic shift(input bit ir_path, input int n, input logic [63:0] din,
                       input logic [63:0] jpat, output int oe_cnt,
                       output logic [NC-1:0] upd_v, output logic [NC-1:0] rti_v);
    oe_cnt = 0;
    tick(1'b1, 1'b0); oe_cnt += int'(s_oe);
    if (ir_path) begin tick(1'b1, 1'b0); oe_cnt += int'(s_oe); end
    tick(1'b0, 1'b0); oe_cnt += int'(s_oe);
    jtdo = {~jpat[0], jpat[0]};
    tick(1'b0, 1'b0); oe_cnt += int'(s_oe);
    obs_q.push_back(s_tdo);
    for (int k = 0; k < n; k++) begin
      jtdo = {~jpat[k+1], jpat[k+1]};
      tick(k == n - 1, din[k]); oe_cnt += int'(s_oe);
      if (k < n - 1) obs_q.push_back(s_tdo);
    end
    tick(1'b1, 1'b0); oe_cnt += int'(s_oe);
    upd_v = s_jupdate;
    tick(1'b0, 1'b0);
    rti_v = s_jrti;
  endtask

  task automatic test_reset();
    int oe; logic [NC-1:0] u, r; logic e, o; logic [7:0] cap;
    reset = 1'b1; tms = 1'b1; tdi = 1'b0; jtdo = '0;
    @(negedge tck); #1;
    checks++; if (tdo !== 1'b0 || tdo_oe !== 1'b0) begin failures++; $display("FAIL reset_tdo: tdo=%b oe=%b required 0 0", tdo, tdo_oe); end
    checks++; if (jrstn !== 1'b0 || jtdi !== 1'b0) begin failures++; $display("FAIL reset_jrstn_jtdi: jrstn=%b jtdi=%b required 0 0", jrstn, jtdi); end
    checks++; if ({jshift, jupdate, jce, jrti} !== '0) begin failures++; $display("FAIL reset_strobes: %b required 0", {jshift, jupdate, jce, jrti}); end
    checks++; if (jtck !== tck) begin failures++; $display("FAIL jtck: %b required %b", jtck, tck); end
    reset = 1'b0;
    tick(1'b1, 1'b0);
    checks++; if (s_jrstn !== 1'b0) begin failures++; $display("FAIL tlr_hold_jrstn: %b required 0", s_jrstn); end
    tick(1'b0, 1'b1);
    checks++; if (s_jrstn !== 1'b1 || s_jtdi !== 1'b1) begin failures++; $display("FAIL leave_tlr: jrstn=%b jtdi=%b required 1 1", s_jrstn, s_jtdi); end
    checks++; if (s_jrti !== 2'b00) begin failures++; $display("FAIL reset_jrti: %b required 00", s_jrti); end
    cap = 8'hE1;
    for (int k = 0; k < 8; k++) exp_q.push_back(cap[k]);
    shift(1'b1, 8, 64'hE0, 64'h0, oe, u, r);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL reset_ir_count: %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL reset_ir_capture: tdo=%b required %b", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_idcode();
    int oe; logic [NC-1:0] u, r; logic e, o; logic [31:0] v;
    v = IDC;
    for (int k = 0; k < 32; k++) exp_q.push_back(v[k]);
    shift(1'b0, 32, 64'h0, 64'h0, oe, u, r);
    checks++; if (oe != 32) begin failures++; $display("FAIL idcode_oe_count: %0d required 32", oe); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL idcode_count: %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL idcode_bit: tdo=%b required %b", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_ir_load();
    int oe; logic [NC-1:0] u, r; logic e, o; logic [7:0] cap;
    shift(1'b1, 8, 64'h38, 64'h0, oe, u, r);
    obs_q.delete();
    cap = 8'h39;
    for (int k = 0; k < 8; k++) exp_q.push_back(cap[k]);
    shift(1'b1, 8, 64'h38, 64'h0, oe, u, r);
    checks++; if (oe != 8) begin failures++; $display("FAIL ir_oe_count: %0d required 8", oe); end
    checks++; if (r !== 2'b10) begin failures++; $display("FAIL ir38_jrti: %b required 10", r); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL ir_count: %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL ir_readback: tdo=%b required %b", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    tick(1'b1, 1'b0);
    checks++; if (s_jce !== 2'b00) begin failures++; $display("FAIL seldr_jce: %b required 00", s_jce); end
    tick(1'b0, 1'b0);
    checks++; if (s_jce !== 2'b10 || s_jshift !== 2'b00) begin failures++; $display("FAIL capdr: jce=%b jshift=%b required 10 00", s_jce, s_jshift); end
    tick(1'b0, 1'b0);
    checks++; if (s_jce !== 2'b10 || s_jshift !== 2'b10) begin failures++; $display("FAIL shdr: jce=%b jshift=%b required 10 10", s_jce, s_jshift); end
    tick(1'b1, 1'b0);
    checks++; if (s_jce !== 2'b00 || s_jshift !== 2'b00) begin failures++; $display("FAIL ex1dr: jce=%b jshift=%b required 00 00", s_jce, s_jshift); end
    tick(1'b1, 1'b0);
    checks++; if (s_jupdate !== 2'b10) begin failures++; $display("FAIL upddr_jupdate: %b required 10", s_jupdate); end
    tick(1'b0, 1'b0);
    checks++; if (s_jupdate !== 2'b00 || s_jrti !== 2'b10) begin failures++; $display("FAIL rti: jupdate=%b jrti=%b required 00 10", s_jupdate, s_jrti); end
  endtask

  task automatic test_chan_tdo();
    int oe; logic [NC-1:0] u, r; logic e, o; logic [7:0] cap; logic [3:0] pat;
    cap = 8'h39;
    for (int k = 0; k < 8; k++) exp_q.push_back(cap[k]);
    shift(1'b1, 8, 64'h32, 64'h0, oe, u, r);
    pat = 4'b1101;
    for (int k = 0; k < 4; k++) exp_q.push_back(pat[k]);
    shift(1'b0, 4, 64'h0, {60'h0, pat}, oe, u, r);
    jtdo = '0;
    checks++; if (u !== 2'b01) begin failures++; $display("FAIL chan0_jupdate: %b required 01", u); end
    checks++; if (r !== 2'b01) begin failures++; $display("FAIL chan0_jrti: %b required 01", r); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL chan_count: %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL chan_tdo: tdo=%b required %b", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bypass();
    int oe; logic [NC-1:0] u, r; logic e, o; logic [7:0] cap; logic [3:0] din;
    cap = 8'h31;
    for (int k = 0; k < 8; k++) exp_q.push_back(cap[k]);
    shift(1'b1, 8, 64'hFF, 64'h0, oe, u, r);
    din = 4'b1101;
    exp_q.push_back(1'b0);
    for (int k = 0; k < 3; k++) exp_q.push_back(din[k]);
    shift(1'b0, 4, {60'h0, din}, 64'h0, oe, u, r);
    checks++; if (u !== 2'b00 || r !== 2'b00) begin failures++; $display("FAIL bypass_strobes: jupdate=%b jrti=%b required 00 00", u, r); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL bypass_count: %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL bypass_tdo: tdo=%b required %b", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_tlr_escape();
    int oe; logic [NC-1:0] u, r; logic e, o; logic [7:0] cap;
    shift(1'b1, 8, 64'h38, 64'h0, oe, u, r);
    obs_q.delete();
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b1, 1'b0);
    checks++; if (s_jrstn !== 1'b1) begin failures++; $display("FAIL pause_esc_4: jrstn=%b required 1", s_jrstn); end
    tick(1'b1, 1'b0);
    checks++; if (s_jrstn !== 1'b0) begin failures++; $display("FAIL pause_esc_5: jrstn=%b required 0", s_jrstn); end
    tick(1'b0, 1'b0);
    cap = 8'hE1;
    for (int k = 0; k < 8; k++) exp_q.push_back(cap[k]);
    shift(1'b1, 8, 64'h38, 64'h0, oe, u, r);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL tlr_ir_count: %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL tlr_ir_capture: tdo=%b required %b", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    checks++; if (s_jrstn !== 1'b0 || s_jrti !== 2'b00) begin failures++; $display("FAIL rti_esc: jrstn=%b jrti=%b required 0 00", s_jrstn, s_jrti); end
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    checks++; if (s_oe !== 1'b1) begin failures++; $display("FAIL shir_oe: %b required 1", s_oe); end
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    checks++; if (s_jrstn !== 1'b0 || s_oe !== 1'b0) begin failures++; $display("FAIL shir_esc: jrstn=%b oe=%b required 0 0", s_jrstn, s_oe); end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_shift();
    int oe; logic [NC-1:0] u, r; logic e, o; logic [31:0] v;
    shift(1'b1, 8, 64'h38, 64'h0, oe, u, r);
    obs_q.delete();
    tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b1); tick(1'b0, 1'b1);
    checks++; if (s_jshift !== 2'b10 || s_oe !== 1'b1) begin failures++; $display("FAIL pre_abort: jshift=%b oe=%b required 10 1", s_jshift, s_oe); end
    reset = 1'b1;
    #1;
    checks++; if (jshift !== 2'b00 || jce !== 2'b00 || tdo_oe !== 1'b0) begin failures++; $display("FAIL abort: jshift=%b jce=%b oe=%b required 00 00 0", jshift, jce, tdo_oe); end
    checks++; if (jrstn !== 1'b0) begin failures++; $display("FAIL abort_jrstn: %b required 0", jrstn); end
    #1;
    reset = 1'b0;
    tick(1'b0, 1'b0);
    v = IDC;
    for (int k = 0; k < 32; k++) exp_q.push_back(v[k]);
    shift(1'b0, 32, 64'h0, 64'h0, oe, u, r);
    checks++; if (oe != 32) begin failures++; $display("FAIL post_abort_oe: %0d required 32", oe); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL post_abort_count: %0d required %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL post_abort_idcode: tdo=%b required %b", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_load();
    test_chan_tdo();
    test_bypass();
    test_tlr_escape();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jtag_tap_multichan.md
Name: jtag_tap_multichan

Overview:
- Parametrised simulation model of an FPGA JTAG TAP. Exposes NUM_CHAN user data-register channels; each channel is selected by its own IR opcode.
- Contains the full IEEE 1149.1 16-state TAP controller, an IR of IR_WIDTH bits, a 32-bit IDCODE register and a 1-bit BYPASS register.
- Sits in tb/ between the bench JTAG driver and the user JTAG-bridge logic. It generalises the fixed two-channel primitive model to N channels.
- Adds three features: standard IR capture, IDCODE/BYPASS instructions, and a driven TDO with a separate enable.

Parameters:
- IR_WIDTH, 8, instruction register width in bits (minimum 2).
- NUM_CHAN, 2, number of user channels (1..8).
- CHAN_OPCODES, {8'h38,8'h32}, packed NUM_CHAN*IR_WIDTH opcodes; slice i selects channel i.
- IDCODE_OPCODE, 8'hE0, opcode that selects the IDCODE register.
- IDCODE_VALUE, 32'h41111043, value captured into the IDCODE register.

Ports:
- tck  in  1  JTAG clock; the only clock. Posedge and negedge are both used.
- reset  in  1  asynchronous, active-high reset.
- tms  in  1  test mode select, sampled on posedge tck.
- tdi  in  1  test data in, sampled on posedge tck.
- tdo  out  1  test data out, updated on negedge tck.
- tdo_oe  out  1  high while tdo is valid (Shift-IR or Shift-DR).
- jtck  out  1  equals tck.
- jtdi  out  1  tdi registered on posedge tck.
- jrstn  out  1  low while the TAP is in Test-Logic-Reset; updated on negedge.
- jshift  out  NUM_CHAN  bit i high in Shift-DR while channel i is selected.
- jupdate  out  NUM_CHAN  bit i high in Update-DR while channel i is selected.
- jce  out  NUM_CHAN  bit i high in Capture-DR or Shift-DR while channel i is selected.
- jrti  out  NUM_CHAN  bit i high in Run-Test/Idle while channel i is selected.
- jtdo  in  NUM_CHAN  channel i serial data toward tdo.

Behaviour:
- Reset values (while reset is high): TAP state = Test-Logic-Reset; ir = IDCODE_OPCODE; ir_shift = 0; idcode_sr = IDCODE_VALUE; bypass_sr = 0; tdo = 0; tdo_oe = 0; jtdi = 0; jrstn = 0.
  - All jshift/jupdate/jce/jrti bits are 0.
- TAP FSM advances on posedge tck. Transitions are written TMS=0 / TMS=1:
  - TLR→RTI/TLR; RTI→RTI/SelDR; SelDR→CapDR/SelIR; SelIR→CapIR/TLR.
  - CapX→ShX/Ex1X; ShX→ShX/Ex1X; Ex1X→PauseX/UpdX; PauseX→PauseX/Ex2X.
  - Ex2X→ShX/UpdX; UpdX→RTI/SelDR (X = DR or IR).
  - Five consecutive TMS=1 clocks reach TLR from any state.
- State decode is combinational from the current state. Each action below takes effect on the posedge that leaves the named state.
- IR path:
  - Capture-IR loads ir_shift = {ir[IR_WIDTH-1:2], 2'b01}.
  - Shift-IR does ir_shift = {tdi, ir_shift[IR_WIDTH-1:1]}.
  - Update-IR loads ir = ir_shift.
  - Being in TLR forces ir = IDCODE_OPCODE.
- Instruction decode:
  - Channel i is selected when ir == CHAN_OPCODES[i].
  - If two slices hold the same opcode, the lowest index wins; only one channel is ever selected.
  - ir == IDCODE_OPCODE selects IDCODE. Any other opcode selects BYPASS (this includes all-ones).
- DR path:
  - IDCODE: Capture-DR loads IDCODE_VALUE; Shift-DR does {tdi, sr[31:1]}.
  - BYPASS: Capture-DR loads 0; Shift-DR loads tdi.
  - Channels: no internal DR; the user logic shifts on jtck qualified by jshift.
- tdo is updated on negedge tck:
  - In Shift-IR: ir_shift[0].
  - In Shift-DR: the LSB of the selected register, or jtdo[i] for selected channel i.
  - Otherwise tdo holds its value. tdo_oe is registered on the same negedge as tdo; it is 1 in Shift-IR/Shift-DR, else 0.
  - Result: the first bit is valid half a cycle after entering Shift, and the last shifted bit stays valid through Exit1.
- jrstn is registered on negedge as !(state==TLR). It is 0 after reset until the first negedge after leaving TLR.
- An IR change takes effect only at Update-IR. The channel strobes follow the new ir from the next state onward.
- Asserting reset mid-shift immediately aborts the shift: TLR, ir = IDCODE_OPCODE, and all strobes go low the same instant. Partial shift contents are lost.
- Deasserting reset: the first posedge with tms=0 moves the TAP to RTI.

Test Plan:
- Reset, then TLR→RTI→Shift-DR and shift 32 bits with tdi=0 → tdo emits 0x41111043 LSB-first; tdo_oe=1 for exactly 32 negedges.
- Load IR=0x38 and read the IR back on the next Shift-IR → the captured pattern LSBs read 1,0, then ir[7:2]=0x0E; after Update-IR, jce=2'b10 in Capture/Shift-DR and jshift=2'b10 only in Shift-DR.
- With IR=0x32, drive jtdo[0] with the pattern 1011 during Shift-DR → tdo shows 1,0,1,1, each bit half a cycle after the posedge; jupdate=2'b01 for one cycle in Update-DR; jrti=2'b01 in RTI.
- IR=0xFF (BYPASS), shift tdi=1,0,1,1 → tdo=0,1,0,1 (one-bit delay, leading captured 0).
- From Pause-DR, clock TMS=1 five times → TLR, ir=0xE0, jrstn=0 from the following negedge; from any other start state, five TMS=1 clocks also reach TLR.
- Pulse reset high mid Shift-DR with IR=0x38 → jshift/jce drop to 0 immediately, tdo_oe=0, and a subsequent DR scan returns IDCODE.
